// File: rtl/register_bank.sv
// Bank of DEPTH counter/registers with one op port (load/inc/dec), two
// combinational read ports, synchronous clear and a one-cycle wrap flag.
module register_bank #(
  parameter  int WIDTH   = 8,
  parameter  int DEPTH   = 8,
  parameter  int ZERO_R0 = 0,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic [1:0]       i_op,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_D,
  input  logic [AW-1:0]    i_raddr_a,
  input  logic [AW-1:0]    i_raddr_b,
  output logic [WIDTH-1:0] o_A,
  output logic [WIDTH-1:0] o_B,
  output logic             or_wrap
);

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_DEC  = 2'b11;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             wrap_q;
  logic             wrap_d;
  logic [WIDTH-1:0] cur;
  logic             target_en;

  // Register 0 is a hard-wired zero when ZERO_R0 is set: never written, never wraps.
  assign target_en = !((ZERO_R0 != 0) && (i_waddr == '0));
  assign cur       = regs_q[i_waddr];

  always_comb begin
    regs_d = regs_q;
    wrap_d = 1'b0;
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) regs_d[i] = '0;
    end else if (target_en) begin
      case (i_op)
        OP_LOAD: regs_d[i_waddr] = i_D;
        OP_INC: begin
          regs_d[i_waddr] = cur + WIDTH'(1);
          wrap_d          = &cur;
        end
        OP_DEC: begin
          regs_d[i_waddr] = cur - WIDTH'(1);
          wrap_d          = ~|cur;
        end
        OP_HOLD: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      wrap_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      wrap_q <= wrap_d;
    end
  end

  // Reads show stored state only; a write becomes visible after its edge.
  assign o_A = ((ZERO_R0 != 0) && (i_raddr_a == '0)) ? '0 : regs_q[i_raddr_a];
  assign o_B = ((ZERO_R0 != 0) && (i_raddr_b == '0)) ? '0 : regs_q[i_raddr_b];
  assign or_wrap = wrap_q;

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: two instances (ZERO_R0=0 and 1) on shared inputs,
// directed scenarios then random ops, checked against an array model.
module tb_register_bank;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AW = 3;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] LOAD = 2'b01;
  localparam logic [1:0] INC  = 2'b10;
  localparam logic [1:0] DEC  = 2'b11;

  // clock / reset
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #20 i_clk = ~i_clk;

  logic          i_clr = 1'b0;
  logic [1:0]    i_op = HOLD;
  logic [AW-1:0] i_waddr = '0;
  logic [W-1:0]  i_D = '0;
  logic [AW-1:0] i_raddr_a = '0;
  logic [AW-1:0] i_raddr_b = '0;
  logic [W-1:0]  o_A, o_B, zo_A, zo_B;
  logic          or_wrap, zor_wrap;

  register_bank #(.WIDTH(W), .DEPTH(D), .ZERO_R0(0)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clr), .i_op(i_op),
    .i_waddr(i_waddr), .i_D(i_D), .i_raddr_a(i_raddr_a), .i_raddr_b(i_raddr_b),
    .o_A(o_A), .o_B(o_B), .or_wrap(or_wrap)
  );

  register_bank #(.WIDTH(W), .DEPTH(D), .ZERO_R0(1)) dut_z (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clr), .i_op(i_op),
    .i_waddr(i_waddr), .i_D(i_D), .i_raddr_a(i_raddr_a), .i_raddr_b(i_raddr_b),
    .o_A(zo_A), .o_B(zo_B), .or_wrap(zor_wrap)
  );

  // reference model
  int  m  [D];
  int  mz [D];
  bit  mw, mwz;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m[i] = 0;
      mz[i] = 0;
    end
    mw = 0;
    mwz = 0;
  endtask

  // Arithmetic view of one edge: values in 0..255, wrap when the sum leaves that range.
  task automatic model_edge(input logic [1:0] op, input int a, input int d, input bit clr);
    int nv;
    bit nw;
    if (clr) begin
      model_reset();
      return;
    end
    for (int z = 0; z < 2; z++) begin
      int old;
      old = (z == 0) ? m[a] : mz[a];
      nv = old;
      nw = 0;
      case (op)
        LOAD: nv = d;
        INC: begin
          nw = (old + 1 == 256);
          nv = (old + 1) % 256;
        end
        DEC: begin
          nw = (old - 1 < 0);
          nv = (old + 255) % 256;
        end
        default: ;
      endcase
      if (z == 0) begin
        m[a] = nv;
        mw = nw;
      end else if (a != 0) begin
        mz[a] = nv;
        mwz = nw;
      end else begin
        mwz = 0;
      end
    end
  endtask

  // Sweeps both read ports over every register of both instances.
  task automatic check_all(input string tag);
    i_raddr_a = i_waddr;
    i_raddr_b = i_waddr;
    #1;
    chk({tag, "_same_addr"}, o_A, o_B);
    for (int i = 0; i < D; i++) begin
      i_raddr_a = AW'(i);
      i_raddr_b = AW'(D - 1 - i);
      #1;
      chk({tag, "_A"}, o_A, W'(m[i]));
      chk({tag, "_B"}, o_B, W'(m[D - 1 - i]));
      chk({tag, "_zA"}, zo_A, W'(mz[i]));
      chk({tag, "_zB"}, zo_B, W'(mz[D - 1 - i]));
    end
    chk({tag, "_wrap"}, W'(or_wrap), W'(mw));
    chk({tag, "_zwrap"}, W'(zor_wrap), W'(mwz));
  endtask

  // driver: apply one op for one edge, then check everything
  task automatic step(input string tag, input logic [1:0] op, input int a,
                      input int d, input bit clr);
    i_op = op;
    i_waddr = AW'(a);
    i_D = W'(d);
    i_clr = clr;
    @(posedge i_clk);
    model_edge(op, a, d, clr);
    #1;
    i_op = HOLD;
    i_clr = 1'b0;
    check_all(tag);
  endtask

  initial begin
    int r, dv;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check_all("reset");
    #2 i_rst_n = 1'b1;

    // async reset pulse between edges
    step("load_r3", LOAD, 3, 8'hA5, 0);
    #2 i_rst_n = 1'b0;
    i_raddr_a = 3;
    #1;
    chk("async_rst_r3", o_A, 8'h00);
    chk("async_rst_wrap", W'(or_wrap), 8'h00);
    model_reset();
    #1 i_rst_n = 1'b1;

    // no write-through
    i_op = LOAD;
    i_waddr = 2;
    i_D = 8'h7F;
    i_raddr_a = 2;
    #1;
    chk("r2_before_edge", o_A, 8'h00);
    @(posedge i_clk);
    model_edge(LOAD, 2, 8'h7F, 0);
    #1;
    i_op = HOLD;
    i_raddr_a = 2;
    i_raddr_b = 1;
    #1;
    chk("r2_after_edge", o_A, 8'h7F);
    chk("r1_unchanged", o_B, 8'h00);
    check_all("load_r2");

    // increment wrap
    step("load_r5", LOAD, 5, 8'hFE, 0);
    step("inc_r5_a", INC, 5, 0, 0);
    chk("r5_ff_nowrap", W'(or_wrap), 8'h00);
    step("inc_r5_b", INC, 5, 0, 0);
    chk("r5_wrap_set", W'(or_wrap), 8'h01);
    step("hold_r5", HOLD, 5, 0, 0);
    chk("r5_wrap_cleared", W'(or_wrap), 8'h00);

    // decrement wrap
    step("dec_r4", DEC, 4, 0, 0);
    chk("r4_wrap_set", W'(or_wrap), 8'h01);
    step("hold_r4", HOLD, 4, 0, 0);
    chk("r4_wrap_cleared", W'(or_wrap), 8'h00);

    // clear beats load
    step("load_r6", LOAD, 6, 8'h10, 0);
    step("clr_vs_load", LOAD, 6, 8'h55, 1);
    i_raddr_a = 6;
    #1;
    chk("r6_cleared", o_A, 8'h00);

    // zero register 0
    step("load_r0", LOAD, 0, 8'hAA, 0);
    step("dec_r0", DEC, 0, 0, 0);
    i_raddr_a = 0;
    #1;
    chk("z_r0_zero", zo_A, 8'h00);
    chk("z_r0_nowrap", W'(zor_wrap), 8'h00);
    step("clr2", HOLD, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step("inc_r7", INC, 7, 0, 0);
      i_raddr_b = 7;
      #1;
      chk("z_r7_count", zo_B, W'(i + 1));
    end

    // reset coinciding with an edge discards the op
    i_op = INC;
    i_waddr = 1;
    i_rst_n = 1'b0;
    @(posedge i_clk);
    model_reset();
    #1;
    check_all("rst_at_edge");
    #2 i_rst_n = 1'b1;
    i_op = HOLD;

    // random ops with values biased toward wrap boundaries
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 3);
      dv = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : (r == 2) ? 8'hFE : $urandom_range(0, 255);
      step("rand", 2'($urandom_range(0, 3)), $urandom_range(0, D - 1), dv,
           $urandom_range(0, 24) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
